// File: rtl/bcd_pkg.sv
// Shared types and constants for the four-digit BCD scan counter.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package bcd_pkg;

    localparam int unsigned NUM_DIGITS = 4;

    typedef logic [3:0] bcd_digit_t;

    localparam bcd_digit_t BCD_MAX = 4'd9;

    // True when every nibble of a packed four-digit word is a legal decimal digit.
    function automatic logic bcd_word_ok(input logic [4*NUM_DIGITS-1:0] w);
        logic ok;
        ok = 1'b1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (w[4*i +: 4] > BCD_MAX) begin
                ok = 1'b0;
            end
        end
        return ok;
    endfunction

endpackage

// File: rtl/bcd_digit_cell.sv
// One decade of the BCD counter: clear, load, or step up/down when carry-in is set.
// Latency: digit updates on the next rising edge; carry-out is combinational from the held digit.
// Backpressure: none; chained cells ripple carry/borrow within one cycle.
//
// Ports: clk/rst_n clock and async reset; clr_i, load_i, load_dig_i synchronous controls;
//        ci_i carry/borrow in (step request); up_i direction; dig_o held digit; co_o carry/borrow out.
module bcd_digit_cell
    import bcd_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clr_i,
    input  logic       load_i,
    input  bcd_digit_t load_dig_i,
    input  logic       ci_i,
    input  logic       up_i,
    output bcd_digit_t dig_o,
    output logic       co_o
);

    bcd_digit_t dig_q;
    bcd_digit_t dig_d;

    always_comb begin
        dig_d = dig_q;
        if (clr_i) begin
            dig_d = '0;
        end else if (load_i) begin
            dig_d = load_dig_i;
        end else if (ci_i) begin
            if (up_i) begin
                dig_d = (dig_q == BCD_MAX) ? 4'd0 : dig_q + 4'd1;
            end else begin
                dig_d = (dig_q == 4'd0) ? BCD_MAX : dig_q - 4'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dig_q <= '0;
        end else begin
            dig_q <= dig_d;
        end
    end

    // The next decade steps only when this one is stepping across its wrap point.
    assign co_o  = ci_i && (up_i ? (dig_q == BCD_MAX) : (dig_q == 4'd0));
    assign dig_o = dig_q;

endmodule

// File: rtl/bcd_scan_counter.sv
// Four-digit up/down BCD counter with clear/load, wrap pulse, and multiplexed 7-segment scan.
// Latency: count/carry/load_err one cycle after sampled request; scan slot = SCAN_DIV cycles.
// Backpressure: none; clr > load > en, lower-priority requests in the same cycle are dropped.
//
// Ports: clk, rst_n; clr, load, load_val, en, up control inputs;
//        count (registered BCD), carry (wrap pulse), load_err (rejected load pulse),
//        bcd (scanned digit), dig_sel (one-hot digit enable).
module bcd_scan_counter
    import bcd_pkg::*;
#(
    parameter int unsigned SCAN_DIV = 1000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clr,
    input  logic        load,
    input  logic [15:0] load_val,
    input  logic        en,
    input  logic        up,
    output logic [15:0] count,
    output logic        carry,
    output logic        load_err,
    output logic [3:0]  bcd,
    output logic [3:0]  dig_sel
);

    localparam logic [15:0] PRESC_LAST = 16'(SCAN_DIV - 1);

    logic                  load_ok;
    logic                  load_go;
    logic                  step_go;
    logic [NUM_DIGITS:0]   chain;
    bcd_digit_t            digs [NUM_DIGITS];

    logic                  carry_q;
    logic                  load_err_q;
    logic                  load_err_d;
    logic [15:0]           presc_q;
    logic [1:0]            idx_q;
    logic [3:0]            dig_sel_q;

    assign load_ok = bcd_word_ok(load_val);
    assign load_go = load && !clr && load_ok;
    // A rejected load still outranks en, so stepping is suppressed whenever load is high.
    assign step_go = en && !clr && !load;
    assign load_err_d = load && !clr && !load_ok;

    assign chain[0] = step_go;

    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_dig
        bcd_digit_cell u_cell (
            .clk        (clk),
            .rst_n      (rst_n),
            .clr_i      (clr),
            .load_i     (load_go),
            .load_dig_i (load_val[4*g +: 4]),
            .ci_i       (chain[g]),
            .up_i       (up),
            .dig_o      (digs[g]),
            .co_o       (chain[g+1])
        );
        assign count[4*g +: 4] = digs[g];
    end

    // Carry out of the top decade is exactly the 9999<->0000 wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            carry_q    <= 1'b0;
            load_err_q <= 1'b0;
        end else begin
            carry_q    <= chain[NUM_DIGITS];
            load_err_q <= load_err_d;
        end
    end

    // Scan timing runs free of the counting controls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q   <= '0;
            idx_q     <= '0;
            dig_sel_q <= 4'b0001;
        end else if (presc_q == PRESC_LAST) begin
            presc_q   <= '0;
            idx_q     <= idx_q + 2'd1;
            dig_sel_q <= {dig_sel_q[2:0], dig_sel_q[3]};
        end else begin
            presc_q   <= presc_q + 16'd1;
        end
    end

    assign carry    = carry_q;
    assign load_err = load_err_q;
    assign dig_sel  = dig_sel_q;
    assign bcd      = digs[idx_q];

endmodule
